// File: rtl/seq_chunk_comparator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : seq_chunk_comparator                                         |
// | Description : Multi-cycle signed/unsigned magnitude comparator, CHUNK bits |
// |               per cycle, MSB chunk first, early exit on first difference.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module seq_chunk_comparator #(
  parameter  int WIDTH  = 32,
  parameter  int CHUNK  = 8,
  localparam int NCHUNK = WIDTH / CHUNK,
  localparam int CW     = $clog2(NCHUNK) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             signed_mode,
  output logic             busy,
  output logic             done,
  output logic             le,
  output logic             eq,
  output logic             gr,
  output logic [CW-1:0]    cycles
);

  typedef enum logic [0:0] {
    c_S_IDLE = 1'b0,
    c_S_CMP  = 1'b1
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [CW-1:0]    r_idx;

  logic [WIDTH-1:0] w_sign_flip;
  logic [WIDTH-1:0] w_a_next;
  logic [WIDTH-1:0] w_b_next;
  logic [CHUNK-1:0] w_ca;
  logic [CHUNK-1:0] w_cb;
  logic             w_last;

  // Flipping the sign bits maps two's-complement order onto unsigned order.
  assign w_sign_flip = {signed_mode, {(WIDTH-1){1'b0}}};

  // The chunk under test always sits at the top; equal chunks shift out.
  assign w_ca   = r_a[WIDTH-1 -: CHUNK];
  assign w_cb   = r_b[WIDTH-1 -: CHUNK];
  assign w_last = (r_idx == '0);

  generate
    if (NCHUNK > 1) begin : g_multi
      assign w_a_next = {r_a[WIDTH-CHUNK-1:0], {CHUNK{1'b0}}};
      assign w_b_next = {r_b[WIDTH-CHUNK-1:0], {CHUNK{1'b0}}};
    end else begin : g_single
      assign w_a_next = r_a;
      assign w_b_next = r_b;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_idx   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      le      <= 1'b0;
      eq      <= 1'b0;
      gr      <= 1'b0;
      cycles  <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        c_S_IDLE: begin
          if (start) begin
            r_a     <= in1 ^ w_sign_flip;
            r_b     <= in2 ^ w_sign_flip;
            r_idx   <= CW'(NCHUNK - 1);
            le      <= 1'b0;
            eq      <= 1'b0;
            gr      <= 1'b0;
            cycles  <= '0;
            busy    <= 1'b1;
            r_state <= c_S_CMP;
          end
        end
        c_S_CMP: begin
          cycles <= cycles + CW'(1);
          if ((w_ca != w_cb) || w_last) begin
            gr      <= (w_ca > w_cb);
            le      <= (w_ca < w_cb);
            eq      <= (w_ca == w_cb);
            done    <= 1'b1;
            busy    <= 1'b0;
            r_state <= c_S_IDLE;
          end else begin
            r_idx <= r_idx - CW'(1);
            r_a   <= w_a_next;
            r_b   <= w_b_next;
          end
        end
        default: r_state <= c_S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seq_chunk_comparator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_seq_chunk_comparator                                      |
// | Description : Table-driven scoreboard bench for CHUNK=8 and CHUNK=32.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_seq_chunk_comparator;

  localparam int         c_W  = 32;
  localparam logic [2:0] c_LE = 3'b100;  // {le,eq,gr}
  localparam logic [2:0] c_EQ = 3'b010;
  localparam logic [2:0] c_GR = 3'b001;
  localparam int         c_NV = 13;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic           start8 = 1'b0;
  logic           start32 = 1'b0;
  logic           sm = 1'b0;
  logic [c_W-1:0] in1 = '0;
  logic [c_W-1:0] in2 = '0;

  logic       busy8, done8, le8, eq8, gr8;
  logic [2:0] cyc8;
  logic       busy32, done32, le32, eq32, gr32;
  logic [0:0] cyc32;

  always #5 clk = ~clk;

  seq_chunk_comparator #(.WIDTH(32), .CHUNK(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .in1(in1), .in2(in2),
    .signed_mode(sm), .busy(busy8), .done(done8), .le(le8), .eq(eq8),
    .gr(gr8), .cycles(cyc8)
  );

  seq_chunk_comparator #(.WIDTH(32), .CHUNK(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .start(start32), .in1(in1), .in2(in2),
    .signed_mode(sm), .busy(busy32), .done(done32), .le(le32), .eq(eq32),
    .gr(gr32), .cycles(cyc32)
  );

  typedef struct {
    logic [c_W-1:0] a;
    logic [c_W-1:0] b;
    logic           s;
    logic [2:0]     res;
    int             cyc;
  } vec_t;

  typedef struct {
    logic [2:0] res;
    int         cyc;
  } exp_t;

  vec_t tbl [c_NV];
  exp_t q8[$];
  exp_t q32[$];
  exp_t e8, e32;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every done pulse consumes one expected result.
  always @(negedge clk) begin
    if (done8 === 1'b1) begin
      if (q8.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL done8 with empty scoreboard: got done=1, expected none (t=%0t)", $time);
      end else begin
        e8 = q8.pop_front();
        check("result8 {le,eq,gr}", {le8, eq8, gr8}, e8.res);
        check("cycles8", cyc8, e8.cyc);
      end
    end
    if (done32 === 1'b1) begin
      if (q32.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL done32 with empty scoreboard: got done=1, expected none (t=%0t)", $time);
      end else begin
        e32 = q32.pop_front();
        check("result32 {le,eq,gr}", {le32, eq32, gr32}, e32.res);
        check("cycles32", cyc32, e32.cyc);
      end
    end
  end

  // Issues one compare and waits for its done. b2b skips the alignment wait so
  // start can be raised in the done cycle; mid pulses start again during CMP.
  task automatic run_op(input bit wide, input vec_t v, input int cyc, input bit mid, input bit b2b);
    exp_t e;
    int   k;
    if (!b2b) @(negedge clk);
    in1 = v.a; in2 = v.b; sm = v.s;
    e.res = v.res; e.cyc = cyc;
    if (wide) begin start32 = 1'b1; q32.push_back(e); end
    else      begin start8  = 1'b1; q8.push_back(e);  end
    @(posedge clk); #1;
    start8 = 1'b0; start32 = 1'b0;
    check("busy after start", wide ? busy32 : busy8, 1);
    check("done after start", wide ? done32 : done8, 0);
    check("results cleared", wide ? {le32, eq32, gr32} : {le8, eq8, gr8}, 0);
    check("cycles cleared", wide ? 3'(cyc32) : cyc8, 0);
    in1 = ~v.a; in2 = v.b ^ 32'h5A5A_5A5A; sm = ~v.s;
    k = 0;
    while (k < 20 && (wide ? done32 : done8) !== 1'b1) begin
      if (mid && k == 0) start8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0;
      k++;
    end
    check("latency", k, cyc);
    check("busy at done", wide ? busy32 : busy8, 0);
  endtask

  initial begin
    tbl[0]  = '{32'h0000_0001, 32'h0000_0002, 1'b0, c_LE, 4};
    tbl[1]  = '{32'h0500_0000, 32'h02FF_FFFF, 1'b0, c_GR, 1};
    tbl[2]  = '{32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, c_EQ, 4};
    tbl[3]  = '{32'h0000_0000, 32'h0000_0000, 1'b0, c_EQ, 4};
    tbl[4]  = '{32'h0000_0105, 32'h0000_0109, 1'b0, c_LE, 4};
    tbl[5]  = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b1, c_LE, 1};
    tbl[6]  = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, c_GR, 1};
    tbl[7]  = '{32'h8000_0000, 32'h7FFF_FFFF, 1'b1, c_LE, 1};
    tbl[8]  = '{32'hFFFF_FFFB, 32'hFFFF_FFFD, 1'b1, c_LE, 4};
    tbl[9]  = '{32'h1234_5600, 32'h1234_5700, 1'b0, c_LE, 3};
    tbl[10] = '{32'h1234_0000, 32'h12FF_0000, 1'b0, c_LE, 2};
    tbl[11] = '{32'h7FFF_FFFF, 32'h8000_0000, 1'b1, c_GR, 1};
    tbl[12] = '{32'h7FFF_FFFF, 32'h8000_0000, 1'b0, c_LE, 1};

    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset state dut8", {busy8, done8, le8, eq8, gr8, cyc8}, 0);
    check("reset state dut32", {busy32, done32, le32, eq32, gr32, cyc32}, 0);
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < c_NV; i++) begin
      run_op(1'b0, tbl[i], tbl[i].cyc, 1'b0, 1'b0);
      if (tbl[i].res == c_GR && tbl[i].cyc == 1 && tbl[i].s == 1'b0) begin
        repeat (3) @(posedge clk);
        #1;
        check("hold result", {le8, eq8, gr8}, c_GR);
        check("hold cycles", cyc8, 1);
        check("done one cycle", done8, 0);
      end
    end

    // start during CMP with different operands must be ignored
    run_op(1'b0, tbl[0], 4, 1'b1, 1'b0);

    // reset mid-compare aborts with no done
    @(negedge clk);
    in1 = 32'h1; in2 = 32'h2; sm = 1'b0; start8 = 1'b1;
    @(posedge clk); #1 start8 = 1'b0;
    @(posedge clk); #2 rst_n = 1'b0;
    #1 check("async abort outputs", {busy8, done8, le8, eq8, gr8, cyc8}, 0);
    @(posedge clk); #2 rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1 check("idle after abort", busy8, 0);
    run_op(1'b0, tbl[0], 4, 1'b0, 1'b0);

    // start in the done cycle: no idle gap
    run_op(1'b0, '{32'h0000_0009, 32'h0000_0009, 1'b0, c_EQ, 4}, 4, 1'b0, 1'b1);

    for (int i = 0; i < c_NV; i++) begin
      run_op(1'b1, tbl[i], 1, 1'b0, 1'b0);
    end

    repeat (2) @(negedge clk);
    check("scoreboard8 drained", q8.size(), 0);
    check("scoreboard32 drained", q32.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
